tape_controller: RTL and testbench
==================================

// Module: tape_controller
// PURPOSE
//  Turing-machine sequencer that drives the 8-cell, 2-bit-symbol tape store as its sole initiator.
//  Each step reads the cell under the head, looks up (state, symbol) in a rule table supplied on a
//  port, writes the new symbol, moves the head and updates the state.
//  Sits between top-level start/status logic and the tape instance; owns the tape mode/head/in
//  lines and consumes tape out.
// PARAMETERS
//  SW         2    state-register width; NS = 2**SW machine states
//  HALT       3    halting state (0..NS-1); state 0 is the start state
//  MAX_STEPS  255  step budget; exceeding it raises a timeout fault
//  CW         8    width of step_count
// PORTS
//  clk         in   1            system clock; all logic on posedge
//  reset       in   1            synchronous, active-low reset
//  start       in   1            1-cycle pulse; accepted only in IDLE, DONE or FAULT
//  start_head  in   3            initial head position, sampled with start
//  rules       in   NS*3*(SW+4)  rule table, entry e = state*3+sym at [e*(SW+4) +: SW+4]
//                                entry fields: [SW+3:4] next state, [3:2] write sym, [1:0] move
//  tape_mode   out  1            0 = read, 1 = write (to tape mode)
//  tape_head   out  3            cell index (to tape head)
//  tape_in     out  2            symbol to write (to tape in)
//  tape_out    in   2            registered read data (from tape out)
//  busy        out  1            1 while a run is in progress
//  done        out  1            1 after reaching HALT; held until next start
//  fault       out  1            1 after abnormal stop; held until next start
//  fault_code  out  2            01 head underflow, 10 head overflow, 11 step timeout
//  tm_state    out  SW           current machine state
//  step_count  out  CW           completed steps in the current run
// BEHAVIOUR
//  Symbol encoding: 00 = '0', 01 = '1', 1x = blank, mapped to table index 0/1/2.
//    The controller always writes 10 for blank.
//  Move encoding: 00 stay, 01 right (head+1), 10 left (head-1), 11 stay.
//  Reset (reset==0 at posedge): FSM to IDLE; tape_mode=0, tape_head=0, tape_in=00,
//    busy=0, done=0, fault=0, fault_code=00, tm_state=0, step_count=0.
//    Reset takes priority mid-run; any pending write is abandoned.
//  FSM states:
//    IDLE/DONE/FAULT --start--> READ. On start: head<=start_head, tm_state<=0, step_count<=0,
//      done/fault/fault_code cleared, busy<=1.
//      If start_head is applied and state 0 == HALT, go straight to DONE.
//    READ:  tape_mode=0, tape_head=head. Tape captures out on this edge. Go to LATCH.
//    LATCH: tape_out is valid. Register sym index, look up the rule entry, register
//      next/wsym/move. Go to WRITE.
//    WRITE: tape_mode=1, tape_head=head, tape_in=wsym. Tape commits on this edge.
//      Same edge: tm_state<=next, step_count+1 (saturating), head per move. Then choose:
//        - next==HALT -> DONE, done=1.
//        - left at head 0 -> FAULT 01; head stays 0.
//        - right at head 7 -> FAULT 10; head stays 7.
//        - step_count reaches MAX_STEPS with next!=HALT -> FAULT 11.
//        - otherwise -> READ.
//      Priority: HALT > boundary > timeout. The write always completes, even on a fault.
//  Each step takes exactly 3 cycles (READ, LATCH, WRITE).
//  tape_mode is 1 only in WRITE, so no spurious tape writes occur.
//  Outputs are registered. busy=0 in IDLE/DONE/FAULT; done and fault are never both 1.
//  start while busy is ignored. The rules input must stay stable while busy.
// TESTING
//  1. Reset with reset=0 for 2 cycles -> all outputs at reset values; tape_mode stays 0.
//  2. Tape "1,1,0,blank...", head 0. Rules: s0 reading 0 or 1 -> write 1, move right, s0;
//     s0 reading blank -> write 1, stay, HALT(3).
//     Expect done after 4 steps / 12 cycles, cells 0..3 = 01, step_count=4.
//  3. Rule s0 reading blank -> move left, with start_head=0 -> fault=1, fault_code=01
//     after 1 step; cell 0 written.
//  4. Rule s0 reading any -> move right, s0, start_head=5 -> steps at heads 5,6,7,
//     then fault_code=10, step_count=3.
//  5. MAX_STEPS=4, rule s0 loops in place -> fault_code=11 at step_count=4, busy falls.
//  6. Assert reset=0 during WRITE of step 2 -> next cycle IDLE, no tape write that cycle.
//     Then start runs cleanly. Also: start pulsed while busy -> ignored.

Source files
------------

// File: rtl/tape_controller.sv
// Turing-machine sequencer for an 8-cell, 2-bit-symbol tape store.
// Each step is READ -> LATCH -> WRITE; the rule table arrives on a flat port.
module tape_controller #(
  parameter int SW        = 2,
  parameter int HALT      = 3,
  parameter int MAX_STEPS = 255,
  parameter int CW        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2:0]                    start_head,
  input  logic [(2**SW)*3*(SW+4)-1:0]   rules,
  output logic                          tape_mode,
  output logic [2:0]                    tape_head,
  output logic [1:0]                    tape_in,
  input  logic [1:0]                    tape_out,
  output logic                          busy,
  output logic                          done,
  output logic                          fault,
  output logic [1:0]                    fault_code,
  output logic [SW-1:0]                 tm_state,
  output logic [CW-1:0]                 step_count,
  output logic [2:0]                    dbg_fsm_state
);

  localparam int NS = 2**SW;
  localparam int EW = SW + 4;
  localparam logic [SW-1:0] HALT_S = SW'(HALT);
  localparam logic [CW-1:0] MAX_S  = CW'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [2:0]    head_q, head_d;
  logic [SW-1:0] tm_state_q, tm_state_d;
  logic [CW-1:0] step_q, step_d;
  logic [SW-1:0] nxt_q, nxt_d;
  logic [1:0]    tin_q, tin_d;
  logic [1:0]    move_q, move_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [EW-1:0] rule_tab [NS][3];
  logic [EW-1:0] rule_e;
  logic [CW-1:0] step_inc;
  logic          mv_left, mv_right;

  for (genvar s = 0; s < NS; s++) begin : g_state
    for (genvar y = 0; y < 3; y++) begin : g_sym
      assign rule_tab[s][y] = rules[(s*3+y)*EW +: EW];
    end
  end

  // Symbol 1x (blank) maps to table column 2 regardless of bit 0.
  assign rule_e   = tape_out[1] ? rule_tab[tm_state_q][2] :
                    (tape_out[0] ? rule_tab[tm_state_q][1] : rule_tab[tm_state_q][0]);
  assign step_inc = (step_q == '1) ? step_q : step_q + 1'b1;
  assign mv_left  = (move_q == 2'b10);
  assign mv_right = (move_q == 2'b01);

  always_comb begin
    fsm_d      = fsm_q;
    head_d     = head_q;
    tm_state_d = tm_state_q;
    step_d     = step_q;
    nxt_d      = nxt_q;
    tin_d      = tin_q;
    move_d     = move_q;
    mode_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    fault_d    = fault_q;
    code_d     = code_q;
    case (fsm_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          head_d     = start_head;
          tm_state_d = '0;
          step_d     = '0;
          fault_d    = 1'b0;
          code_d     = 2'b00;
          if (HALT_S == '0) begin
            fsm_d  = S_DONE;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            fsm_d  = S_READ;
            done_d = 1'b0;
            busy_d = 1'b1;
          end
        end
      end
      S_READ: fsm_d = S_LATCH;
      S_LATCH: begin
        nxt_d  = rule_e[EW-1:4];
        tin_d  = rule_e[3] ? 2'b10 : rule_e[3:2];
        move_d = rule_e[1:0];
        mode_d = 1'b1;
        fsm_d  = S_WRITE;
      end
      S_WRITE: begin
        tm_state_d = nxt_q;
        step_d     = step_inc;
        // The head only moves when the move stays on the tape.
        if (mv_left && head_q != 3'd0)  head_d = head_q - 3'd1;
        if (mv_right && head_q != 3'd7) head_d = head_q + 3'd1;
        if (nxt_q == HALT_S) begin
          fsm_d  = S_DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (mv_left && head_q == 3'd0) begin
          fsm_d   = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'b01;
          busy_d  = 1'b0;
        end else if (mv_right && head_q == 3'd7) begin
          fsm_d   = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'b10;
          busy_d  = 1'b0;
        end else if (step_inc >= MAX_S) begin
          fsm_d   = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'b11;
          busy_d  = 1'b0;
        end else begin
          fsm_d = S_READ;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q      <= S_IDLE;
      head_q     <= 3'd0;
      tm_state_q <= '0;
      step_q     <= '0;
      nxt_q      <= '0;
      tin_q      <= 2'b00;
      move_q     <= 2'b00;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      fsm_q      <= fsm_d;
      head_q     <= head_d;
      tm_state_q <= tm_state_d;
      step_q     <= step_d;
      nxt_q      <= nxt_d;
      tin_q      <= tin_d;
      move_q     <= move_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
    end
  end

  assign tape_mode     = mode_q;
  assign tape_head     = head_q;
  assign tape_in       = tin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;
  assign tm_state      = tm_state_q;
  assign step_count    = step_q;
  assign dbg_fsm_state = fsm_q;

endmodule

// File: tb/tb_tape_controller.sv
// Directed bench for tape_controller with a behavioural 8-cell tape store.
module tb_tape_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  start_head;
  logic [71:0] rules;
  logic        tape_mode;
  logic [2:0]  tape_head;
  logic [1:0]  tape_in;
  logic [1:0]  tape_out;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic [1:0]  tm_state;
  logic [7:0]  step_count;
  logic [2:0]  dbg_fsm_state;

  logic [1:0]  cells [8];
  logic [1:0]  load_img [8];
  logic        load_en;

  int n_checks = 0;
  int n_pass   = 0;

  tape_controller #(.SW(2), .HALT(3), .MAX_STEPS(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_head(start_head),
    .rules(rules), .tape_mode(tape_mode), .tape_head(tape_head),
    .tape_in(tape_in), .tape_out(tape_out), .busy(busy), .done(done),
    .fault(fault), .fault_code(fault_code), .tm_state(tm_state),
    .step_count(step_count), .dbg_fsm_state(dbg_fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tape store: registered read when mode=0, write when mode=1.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 8; i++) cells[i] <= load_img[i];
    end else if (tape_mode) begin
      cells[tape_head] <= tape_in;
    end else begin
      tape_out <= cells[tape_head];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] ent(input logic [1:0] nx, input logic [1:0] w, input logic [1:0] mv);
    return {nx, w, mv};
  endfunction

  task automatic set_rule(input int s, input int y, input logic [5:0] e);
    rules[(s*3+y)*6 +: 6] = e;
  endtask

  task automatic clear_rules;
    for (int s = 0; s < 4; s++)
      for (int y = 0; y < 3; y++) set_rule(s, y, ent(2'd3, 2'b00, 2'b00));
  endtask

  task automatic load_tape(input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] c2, input logic [1:0] c3);
    load_img[0] = c0; load_img[1] = c1; load_img[2] = c2; load_img[3] = c3;
    for (int i = 4; i < 8; i++) load_img[i] = 2'b10;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] h);
    start      = 1'b1;
    start_head = h;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic rules_fill_right;
    clear_rules();
    set_rule(0, 0, ent(2'd0, 2'b01, 2'b01));
    set_rule(0, 1, ent(2'd0, 2'b01, 2'b01));
    set_rule(0, 2, ent(2'd3, 2'b01, 2'b00));
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    start_head = 3'd0;
    rules      = '0;
    load_en    = 1'b0;
    for (int i = 0; i < 8; i++) load_img[i] = 2'b10;
    @(negedge clk);
    load_tape(2'b10, 2'b10, 2'b10, 2'b10);

    // Reset values
    check("rst_mode", tape_mode, 0);
    check("rst_head", tape_head, 0);
    check("rst_in", tape_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_state", tm_state, 0);
    check("rst_steps", step_count, 0);
    check("rst_fsm", dbg_fsm_state, 0);
    reset = 1'b1;
    cycles(1);
    check("idle_mode", tape_mode, 0);
    check("idle_busy", busy, 0);

    // Fill ones rightwards until blank, then halt
    rules_fill_right();
    load_tape(2'b01, 2'b01, 2'b00, 2'b10);
    pulse_start(3'd0);
    check("t2_busy", busy, 1);
    check("t2_fsm_read", dbg_fsm_state, 1);
    cycles(2);
    check("t2_wmode", tape_mode, 1);
    check("t2_win", tape_in, 1);
    cycles(9);
    check("t2_done_early", done, 0);
    cycles(1);
    check("t2_done", done, 1);
    check("t2_busy_end", busy, 0);
    check("t2_fault", fault, 0);
    check("t2_steps", step_count, 4);
    check("t2_state", tm_state, 3);
    check("t2_head", tape_head, 3);
    check("t2_mode_end", tape_mode, 0);
    check("t2_c0", cells[0], 1);
    check("t2_c1", cells[1], 1);
    check("t2_c2", cells[2], 1);
    check("t2_c3", cells[3], 1);
    check("t2_c4", cells[4], 2);

    // Left move at head 0
    clear_rules();
    set_rule(0, 2, ent(2'd0, 2'b00, 2'b10));
    load_tape(2'b10, 2'b10, 2'b10, 2'b10);
    pulse_start(3'd0);
    cycles(3);
    check("t3_fault", fault, 1);
    check("t3_code", fault_code, 1);
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    check("t3_steps", step_count, 1);
    check("t3_head", tape_head, 0);
    check("t3_c0", cells[0], 0);
    check("t3_c1", cells[1], 2);

    // Right move off cell 7
    clear_rules();
    set_rule(0, 0, ent(2'd0, 2'b01, 2'b01));
    set_rule(0, 1, ent(2'd0, 2'b01, 2'b01));
    set_rule(0, 2, ent(2'd0, 2'b01, 2'b01));
    load_tape(2'b10, 2'b10, 2'b10, 2'b10);
    pulse_start(3'd5);
    cycles(8);
    check("t4_busy_mid", busy, 1);
    cycles(1);
    check("t4_fault", fault, 1);
    check("t4_code", fault_code, 2);
    check("t4_steps", step_count, 3);
    check("t4_head", tape_head, 7);
    check("t4_c5", cells[5], 1);
    check("t4_c7", cells[7], 1);

    // Step budget (MAX_STEPS=4), blank written as 10
    clear_rules();
    set_rule(0, 0, ent(2'd0, 2'b11, 2'b11));
    set_rule(0, 1, ent(2'd0, 2'b11, 2'b11));
    set_rule(0, 2, ent(2'd0, 2'b11, 2'b11));
    load_tape(2'b00, 2'b00, 2'b10, 2'b00);
    pulse_start(3'd2);
    cycles(11);
    check("t5_busy_mid", busy, 1);
    cycles(1);
    check("t5_fault", fault, 1);
    check("t5_code", fault_code, 3);
    check("t5_steps", step_count, 4);
    check("t5_busy", busy, 0);
    check("t5_head", tape_head, 2);
    check("t5_c2", cells[2], 2);

    // Reset during WRITE of step 2, then clean rerun with ignored start
    rules_fill_right();
    load_tape(2'b01, 2'b01, 2'b00, 2'b10);
    pulse_start(3'd0);
    cycles(5);
    check("t6_fsm_write", dbg_fsm_state, 3);
    check("t6_wmode", tape_mode, 1);
    reset = 1'b0;
    cycles(1);
    check("t6_fsm_idle", dbg_fsm_state, 0);
    check("t6_mode", tape_mode, 0);
    check("t6_busy", busy, 0);
    check("t6_head", tape_head, 0);
    check("t6_steps", step_count, 0);
    reset = 1'b1;
    load_tape(2'b01, 2'b01, 2'b00, 2'b10);
    pulse_start(3'd0);
    cycles(4);
    pulse_start(3'd6);
    cycles(6);
    check("t6_done_early", done, 0);
    cycles(1);
    check("t6_done", done, 1);
    check("t6_steps2", step_count, 4);
    check("t6_head2", tape_head, 3);
    check("t6_c2", cells[2], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
